gb_oam_dma_arbiter: RTL and testbench
=====================================

Name: gb_oam_dma_arbiter

Overview:
- OAM DMA controller plus single-port memory bus arbiter between the CPU core and the system memory bus.
- A CPU write to the DMA register (FF46) copies DMA_LEN bytes from page {src,00} to OAM (FE00+).
- While DMA runs, the CPU may access only HRAM (FF80-FFFE) and the DMA register itself.
- One clk equals one bus slot. Memory read is combinational and the write commits on the rising edge, as on the existing CPU bus.

Parameters:
- DMA_REG_ADDR, 16'hFF46: address of the DMA source-page register.
- OAM_BASE, 16'hFE00: destination base address.
- DMA_LEN, 160: number of bytes per transfer.
- HRAM_LO, 16'hFF80: lowest CPU-accessible address during DMA.
- HRAM_HI, 16'hFFFE: highest CPU-accessible address during DMA.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_addr_i  in  16  CPU address (addr_o of gb_cpu)
- cpu_data_i  in  8  CPU write data (data_o of gb_cpu)
- cpu_we_i  in  1  CPU write strobe (drive_data_bus of gb_cpu)
- cpu_data_o  out  8  read data returned to the CPU (data_i of gb_cpu)
- mem_addr_o  out  16  memory bus address
- mem_data_o  out  8  memory bus write data
- mem_we_o  out  1  memory write enable, committed on rising edge
- mem_data_i  in  8  memory read data, combinational
- dma_active_o  out  1  high in START, READ and WRITE states

Behaviour:
- Registers:
  - dma_src_q[7:0]: reset 8'hFF.
  - idx_q[7:0]: reset 0.
  - buf_q[7:0]: reset 0.
  - state: IDLE, START, READ, WRITE; reset IDLE.
- Reset: asynchronous, forces IDLE immediately, including mid-transfer. OAM bytes already written are kept. dma_active_o=0 after reset.
- Register access:
  - CPU read of DMA_REG_ADDR returns dma_src_q, in any state.
  - CPU write to DMA_REG_ADDR loads dma_src_q at the edge, in any state. The write is not forwarded to memory (mem_we_o=0 that cycle).
- IDLE (pass-through):
  - mem_addr_o=cpu_addr_i, mem_data_o=cpu_data_i, mem_we_o=cpu_we_i, cpu_data_o=mem_data_i.
  - Exception: accesses to DMA_REG_ADDR are served by the register rules above.
- State transitions:
  - A DMA_REG_ADDR write at edge E0 gives state START in the cycle after E0, with idx_q=0.
  - START -> READ unconditionally. START uses no bus slot; CPU HRAM accesses pass through.
- Source address: src_addr = {page, idx_q}, where page = dma_src_q - 8'h20 if dma_src_q >= 8'hE0 (echo mapping), else dma_src_q.
- READ:
  - mem_addr_o=src_addr, mem_we_o=0.
  - At the edge: buf_q <= mem_data_i, then go to WRITE.
- WRITE:
  - mem_addr_o=OAM_BASE+idx_q, mem_data_o=buf_q, mem_we_o=1.
  - At the edge: idx_q++. Go to IDLE if idx_q==DMA_LEN-1, else READ.
- Arbitration during START, READ and WRITE:
  - CPU access to HRAM_LO..HRAM_HI wins the bus for that cycle and uses the pass-through mapping.
  - In READ or WRITE, the DMA stalls: no state change, no buf_q load, no idx increment. Each stalled cycle delays completion by one.
  - Any other CPU read returns 8'hFF. Any other CPU write is dropped (never reaches memory).
- Restart: a DMA_REG_ADDR write while active loads the new page, sets idx_q=0 and goes to START. A partially written OAM is not rolled back. A restart write takes priority over the same-cycle DMA bus action: that cycle's DMA write is suppressed.
- Latency: with no stalls, dma_active_o rises after E0 and falls after edge E0+1+2*DMA_LEN (E321 at default). The final OAM write commits at that edge.
- Width rules: idx_q never exceeds DMA_LEN-1. The OAM address is a 16-bit sum with no wrap for the default parameters.

Test Plan:
- Idle pass-through: CPU writes 8'h5A to C123, then reads C123 -> mem_we_o pulses with addr C123; cpu_data_o=5A; dma_active_o=0.
- Basic DMA: preload C000-C09F with i^8'h3C, CPU writes 8'hC0 to FF46 -> dma_active_o high for exactly 321 cycles; FE00-FE9F equal to C000-C09F; reading FF46 returns C0.
- Blocking: during DMA, CPU reads 0150 -> 8'hFF; CPU writes 8'h77 to C800 -> memory C800 unchanged; reading FF46 still works.
- HRAM stall: during DMA, 3 CPU accesses to FF90 (one write 8'hAB) -> FF90=AB; dma_active_o falls 3 cycles late (E324); OAM contents still correct.
- Restart plus echo: at byte 50, CPU writes 8'hE1 -> copy restarts from idx 0 with source page C1; FE00-FE9F equal to C100-C19F.
- Async reset at byte 80 -> state IDLE and dma_active_o=0 immediately; FE00-FE4F written, FE50+ untouched; FF46 reads FF.

Source files
------------

// File: rtl/gb_oam_dma_arbiter.sv
// gb_oam_dma_arbiter: OAM DMA engine sharing one memory bus slot per clock with the CPU.
// During a transfer the CPU keeps HRAM and the DMA register; everything else is fenced off.
module gb_oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          DMA_LEN      = 160,
    parameter logic [15:0] HRAM_LO      = 16'hFF80,
    parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_we_i,
    output logic [7:0]  cpu_data_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_data_o,
    output logic        mem_we_o,
    input  logic [7:0]  mem_data_i,
    output logic        dma_active_o
);
    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    state_t     state, state_n;
    logic [7:0] dma_src_q, idx_q, buf_q;
    logic [7:0] dma_src_n, idx_n, buf_n, page;
    logic       reg_hit, reg_wr, hram, cpu_own, dma_own, last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dma_src_q <= 8'hFF;
            idx_q     <= 8'h00;
            buf_q     <= 8'h00;
        end else begin
            state     <= state_n;
            dma_src_q <= dma_src_n;
            idx_q     <= idx_n;
            buf_q     <= buf_n;
        end
    end

    always_comb begin
        reg_hit = cpu_addr_i == DMA_REG_ADDR;
        reg_wr  = reg_hit && cpu_we_i;
        hram    = cpu_addr_i >= HRAM_LO && cpu_addr_i <= HRAM_HI;
        // Echo RAM pages E0-FF alias C0-DF
        page    = dma_src_q >= 8'hE0 ? dma_src_q - 8'h20 : dma_src_q;
        last    = idx_q == 8'(DMA_LEN - 1);
        cpu_own = !reg_hit && (state == IDLE || hram);
        dma_own = !cpu_own && (state == READ || state == WRITE);
        mem_addr_o   = !dma_own ? cpu_addr_i : state == READ ? {page, idx_q} : OAM_BASE + {8'h00, idx_q};
        mem_data_o   = dma_own ? buf_q : cpu_data_i;
        // A restart write in the same cycle as a DMA write wins and drops that write
        mem_we_o     = cpu_own ? cpu_we_i : dma_own && state == WRITE && !reg_wr;
        cpu_data_o   = reg_hit ? dma_src_q : cpu_own ? mem_data_i : 8'hFF;
        dma_active_o = state != IDLE;
        state_n   = state;
        dma_src_n = dma_src_q;
        idx_n     = idx_q;
        buf_n     = buf_q;
        if (reg_wr) begin
            dma_src_n = cpu_data_i;
            idx_n     = 8'h00;
            state_n   = START;
        end else if (state == START) begin
            state_n = READ;
        end else if (dma_own && state == READ) begin
            buf_n   = mem_data_i;
            state_n = WRITE;
        end else if (dma_own && state == WRITE) begin
            idx_n   = last ? 8'h00 : idx_q + 8'd1;
            state_n = last ? IDLE : READ;
        end
    end
endmodule

// File: tb/tb_gb_oam_dma_arbiter.sv
// tb_gb_oam_dma_arbiter: table vectors, directed DMA corner cases and a randomized
// run against a slot-counting reference model of the OAM DMA arbiter.
module tb_gb_oam_dma_arbiter;
    logic        clk, reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic [7:0]  cpu_data_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic        mem_we_o;
    logic [7:0]  mem_data_i;
    logic        dma_active_o;

    bit   [7:0]  mem     [0:65535];
    bit   [7:0]  ref_mem [0:65535];
    logic [7:0]  src_img [0:255];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;
    int          n_cmp, n_bad;

    gb_oam_dma_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data), .cpu_we_i(cpu_we),
        .cpu_data_o(cpu_data_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_we_o(mem_we_o),
        .mem_data_i(mem_data_i), .dma_active_o(dma_active_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    assign mem_data_i = mem[mem_addr_o];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we_o) mem[mem_addr_o] <= mem_data_o;
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        we;
        logic        cc;
        logic [7:0]  cpu;
        logic        mwe;
        logic        act;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
        @(negedge clk);
        cpu_addr = a;
        cpu_data = d;
        cpu_we   = we;
        #4;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = 16'h0000;
        cpu_we   = 1'b0;
        pl_en    = 1'b1;
        pl_addr  = a;
        pl_data  = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic poke_src(input logic [7:0] page, input bit mode);
        for (int i = 0; i < 160; i++) begin
            src_img[i] = mode ? 8'(i * 7 + 1) : 8'(i) ^ 8'h3C;
            poke({page, 8'(i)}, src_img[i]);
        end
    endtask

    task automatic fill_oam(input logic [7:0] v);
        for (int i = 0; i < 160; i++) poke(16'hFE00 + 16'(i), v);
    endtask

    task automatic cmp_oam(input string nm, input int lo, input int hi, input bit use_fill, input logic [7:0] fill);
        int errs;
        errs = 0;
        for (int i = lo; i < hi; i++)
            if (mem[16'hFE00 + 16'(i)] !== (use_fill ? fill : src_img[i])) errs++;
        chk(nm, errs, 0);
    endtask

    task automatic drain(output int n);
        bit done;
        n = 0;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            drive(16'h0000, 8'h00, 1'b0);
            if (dma_active_o) n++;
            else done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: dma_active_o still high after 2000 cycles, want low");
        end
    endtask

    // Reference model state: DMA progress is counted in bus slots, 2 per byte.
    bit          m_act, m_start;
    int          m_t;
    logic [7:0]  m_src, m_buf, m_pg;
    logic [7:0]  pages [4];

    initial begin
        int          n, n2, r;
        logic [15:0] a;
        logic [7:0]  d, exp_cpu;
        logic        we, reg_hit, hram, cpu_own, exp_we;

        n_cmp = 0;
        n_bad = 0;
        pl_en = 0;
        pl_addr = 0;
        pl_data = 0;
        cpu_addr = 0;
        cpu_data = 0;
        cpu_we = 0;
        reset = 1;
        pages = '{8'hC1, 8'hE1, 8'hC0, 8'hF0};
        #23 reset = 0;

        tbl = '{
            '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0},
            '{16'hC123, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
            '{16'hC123, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0},
            '{16'hFF80, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
            '{16'hFFFE, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
            '{16'hFF80, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0},
            '{16'hFF46, 8'hC0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0},
            '{16'h0150, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1},
            '{16'hC800, 8'h77, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1},
            '{16'hFF46, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1},
            '{16'hFF80, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1},
            '{16'hFFFE, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1},
            '{16'hFFFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1},
            '{16'hFF7F, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1}
        };
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].a, tbl[i].d, tbl[i].we);
            if (tbl[i].cc) chk($sformatf("vec%0d_cpu", i), cpu_data_o, tbl[i].cpu);
            chk($sformatf("vec%0d_we", i), mem_we_o, tbl[i].mwe);
            chk($sformatf("vec%0d_act", i), dma_active_o, tbl[i].act);
            if (tbl[i].we && tbl[i].mwe) chk($sformatf("vec%0d_addr", i), mem_addr_o, tbl[i].a);
        end
        drain(n);
        chk("blk_c800", mem[16'hC800], 8'h00);

        // Basic transfer
        poke_src(8'hC0, 0);
        fill_oam(8'hEE);
        drive(16'hFF46, 8'hC0, 1'b1);
        chk("basic_trig_act", dma_active_o, 0);
        drain(n);
        chk("basic_len", n, 321);
        cmp_oam("basic_oam", 0, 160, 0, 8'h00);
        drive(16'hFF46, 8'h00, 1'b0);
        chk("basic_reg", cpu_data_o, 8'hC0);

        // HRAM stall: three HRAM cycles delay completion by three
        fill_oam(8'hEE);
        drive(16'hFF46, 8'hC0, 1'b1);
        for (int i = 0; i < 10; i++) drive(16'h0000, 8'h00, 1'b0);
        drive(16'hFF90, 8'hAB, 1'b1);
        chk("stall_we", mem_we_o, 1);
        chk("stall_addr", mem_addr_o, 16'hFF90);
        drive(16'hFF90, 8'h00, 1'b0);
        chk("stall_rd1", cpu_data_o, 8'hAB);
        drive(16'hFF90, 8'h00, 1'b0);
        chk("stall_rd2", cpu_data_o, 8'hAB);
        drain(n2);
        chk("stall_len", 13 + n2, 324);
        chk("stall_ff90", mem[16'hFF90], 8'hAB);
        cmp_oam("stall_oam", 0, 160, 0, 8'h00);

        // Restart at byte 50 with an echo page
        poke_src(8'hC1, 1);
        fill_oam(8'h00);
        drive(16'hFF46, 8'hC0, 1'b1);
        for (int i = 0; i < 100; i++) drive(16'h0000, 8'h00, 1'b0);
        drive(16'hFF46, 8'hE1, 1'b1);
        chk("restart_act", dma_active_o, 1);
        drain(n);
        chk("restart_len", n, 321);
        cmp_oam("restart_oam", 0, 160, 0, 8'h00);
        drive(16'hFF46, 8'h00, 1'b0);
        chk("restart_reg", cpu_data_o, 8'hE1);

        // Async reset after byte 80 has been read but not written
        poke_src(8'hC0, 0);
        fill_oam(8'hEE);
        drive(16'hFF46, 8'hC0, 1'b1);
        for (int i = 0; i < 162; i++) drive(16'h0000, 8'h00, 1'b0);
        @(posedge clk);
        #2 reset = 1;
        #1 chk("areset_act", dma_active_o, 0);
        @(negedge clk);
        reset = 0;
        cmp_oam("areset_done", 0, 80, 0, 8'h00);
        cmp_oam("areset_untouched", 80, 160, 1, 8'hEE);
        drive(16'hFF46, 8'h00, 1'b0);
        chk("areset_reg", cpu_data_o, 8'hFF);
        drive(16'h0000, 8'h00, 1'b0);
        chk("areset_idle", dma_active_o, 0);

        // Randomized run against the reference model
        @(negedge clk);
        reset = 1;
        #2 reset = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
        m_act = 0;
        m_start = 0;
        m_t = 0;
        m_src = 8'hFF;
        m_buf = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom_range(0, 99);
            d  = 8'($urandom);
            we = 1'($urandom_range(0, 1));
            if (r < 1) begin
                a = 16'hFF46;
                we = 1'b1;
                d = pages[$urandom_range(0, 3)];
            end else if (r < 6) begin
                a = 16'hFF46;
                we = 1'b0;
            end else if (r < 35) a = 16'hFF80 + 16'($urandom_range(0, 126));
            else if (r < 60) a = 16'hC100 + 16'($urandom_range(0, 255));
            else if (r < 75) a = 16'hFE00 + 16'($urandom_range(0, 159));
            else if (r < 80) a = $urandom_range(0, 1) ? 16'hFFFF : 16'hFF7F;
            else a = 16'h0100 + 16'($urandom_range(0, 255));
            drive(a, d, we);
            reg_hit = a == 16'hFF46;
            hram    = a >= 16'hFF80 && a <= 16'hFFFE;
            cpu_own = !reg_hit && (!m_act || hram);
            exp_cpu = reg_hit ? m_src : cpu_own ? ref_mem[a] : 8'hFF;
            exp_we  = cpu_own ? we : m_act && !m_start && (m_t % 2 == 1) && !(reg_hit && we);
            chk($sformatf("rnd%0d_cpu", c), cpu_data_o, exp_cpu);
            chk($sformatf("rnd%0d_we", c), mem_we_o, exp_we);
            chk($sformatf("rnd%0d_act", c), dma_active_o, m_act);
            if (cpu_own && we) ref_mem[a] = d;
            if (reg_hit && we) begin
                m_src = d;
                m_act = 1;
                m_start = 1;
                m_t = 0;
            end else if (m_act) begin
                if (m_start) m_start = 0;
                else if (!hram) begin
                    m_pg = m_src >= 8'hE0 ? m_src - 8'h20 : m_src;
                    if (m_t % 2 == 0) m_buf = ref_mem[{m_pg, 8'(m_t / 2)}];
                    else ref_mem[16'hFE00 + 16'(m_t / 2)] = m_buf;
                    m_t++;
                    if (m_t == 320) m_act = 0;
                end
            end
        end
        @(posedge clk);
        #1 n = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) n++;
        chk("rnd_mem_image", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
